// File: rtl/interp4x_stereo_192.sv
// Dual-channel linear 4x interpolator (48 kHz -> 192 kHz) for the stereo multiplex path.
// Optional macro INTERP_ROUND_EN selects round-half-up; default truncates toward -inf.
module interp4x_stereo_192 (
  input  logic               clock,
  input  logic               reset,
  input  logic               enableclk48,
  input  logic               enableclk192,
  input  logic signed [17:0] LpR_in,
  input  logic signed [17:0] LmR_in,
  output logic signed [17:0] LpR_out,
  output logic signed [17:0] LmR_out,
  output logic               out_valid
);

  logic [1:0][17:0] in_w;
  logic [1:0]       phase_q, phase_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             load_w, emit_w, run_w, hold_w;

  assign in_w   = {LmR_in, LpR_in};
  assign load_w = enableclk48;
  assign emit_w = enableclk192;
  // done_q marks that all four interpolated points of the interval have been
  // emitted; further strobes without a fresh load hold the newest sample.
  assign run_w  = emit_w && (load_w || !done_q);
  assign hold_w = emit_w && !load_w && done_q;

  always_comb begin
    phase_d = phase_q;
    done_d  = done_q;
    valid_d = emit_w;
    if (load_w) begin
      phase_d = 2'd0;
      done_d  = 1'b0;
    end
    if (run_w) begin
      if (phase_d == 2'd3) begin
        done_d = 1'b1;
      end else begin
        phase_d = phase_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= 2'd0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic signed [17:0] in_s;
    logic signed [17:0] s1_q, s1_d;
    logic signed [18:0] d_q, d_d, d_new, d_e;
    logic signed [20:0] acc_q, acc_d, acc_load, acc_e;
    logic signed [17:0] out_q, out_d, out_r;

    assign in_s = in_w[gi];

    // The older sample s0 is never stored: it only ever appears as 4*s0,
    // which is exactly what acc is loaded with before s1 is overwritten.
    assign d_new    = 19'(in_s) - 19'(s1_q);
    assign acc_load = 21'(s1_q) <<< 2;
    assign acc_e    = load_w ? acc_load : acc_q;
    assign d_e      = load_w ? d_new : d_q;

`ifdef INTERP_ROUND_EN
    logic signed [21:0] rnd_sum;
    assign rnd_sum = 22'(acc_e) + 22'sd2;
    assign out_r   = 18'(rnd_sum >>> 2);
`else
    assign out_r   = 18'(acc_e >>> 2);
`endif

    always_comb begin
      s1_d  = s1_q;
      d_d   = d_q;
      acc_d = acc_e;
      out_d = out_q;
      if (load_w) begin
        s1_d = in_s;
        d_d  = d_new;
      end
      if (run_w) begin
        out_d = out_r;
        acc_d = acc_e + 21'(d_e);
      end else if (hold_w) begin
        out_d = s1_q;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        s1_q  <= '0;
        d_q   <= '0;
        acc_q <= '0;
        out_q <= '0;
      end else begin
        s1_q  <= s1_d;
        d_q   <= d_d;
        acc_q <= acc_d;
        out_q <= out_d;
      end
    end
  end

  assign LpR_out = g_ch[0].out_q;
  assign LmR_out = g_ch[1].out_q;

endmodule
